// File: rtl/shader_pkg.sv
// ---------------------------------------------------------------------------
// shader_pkg
//   Shared definitions for the shader execute core:
//     - opcode group localparams (instr[7:6])
//     - 4-bit single-arg subop enum (instr[5:2])
//     - 2-bit logic / arithmetic subops (instr[5:4])
//     - 16-entry x 6-bit quarter-wave sine table
//     - decoded-instruction struct and field extraction functions
// ---------------------------------------------------------------------------
package shader_pkg;

    // Opcode groups
    localparam logic [1:0] GRP_SINGLE = 2'b00;
    localparam logic [1:0] GRP_LOGIC  = 2'b01;
    localparam logic [1:0] GRP_ARITH  = 2'b10;
    localparam logic [1:0] GRP_LDI    = 2'b11;

    // Single-argument subops
    typedef enum logic [3:0] {
        OP_SETRGB  = 4'h0,
        OP_SETR    = 4'h1,
        OP_SETG    = 4'h2,
        OP_SETB    = 4'h3,
        OP_GETX    = 4'h4,
        OP_GETY    = 4'h5,
        OP_GETTIME = 4'h6,
        OP_GETUSER = 4'h7,
        OP_IFEQ    = 4'h8,
        OP_IFNE    = 4'h9,
        OP_IFGE    = 4'hA,
        OP_IFLT    = 4'hB,
        OP_MUL     = 4'hC,
        OP_DOUBLE  = 4'hD,
        OP_HALF    = 4'hE,
        OP_SINE    = 4'hF
    } subop_e;

    // Logic group subops
    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_NOT = 2'b10;
    localparam logic [1:0] LOP_XOR = 2'b11;

    // Arithmetic group subops
    localparam logic [1:0] AOP_MOV = 2'b00;
    localparam logic [1:0] AOP_ADD = 2'b01;
    localparam logic [1:0] AOP_SHL = 2'b10;
    localparam logic [1:0] AOP_SHR = 2'b11;

    // Quarter-wave sine, index 15 first in the packed literal
    localparam logic [15:0][5:0] SINE_LUT = {
        6'd63, 6'd62, 6'd61, 6'd59, 6'd57, 6'd54, 6'd50, 6'd46,
        6'd42, 6'd37, 6'd31, 6'd25, 6'd19, 6'd13, 6'd6,  6'd0
    };

    typedef struct packed {
        logic [1:0] grp;
        subop_e     subop;
        logic [1:0] op2;    // logic / arith subop
        logic [1:0] arg0;   // destination / single operand
        logic [1:0] arg1;   // second operand
        logic [5:0] imm;
    } instr_t;

    function automatic logic [1:0] arg0(input logic [7:0] instr);
        return instr[1:0];
    endfunction

    function automatic logic [1:0] arg1(input logic [7:0] instr);
        return instr[3:2];
    endfunction

    function automatic instr_t decode(input logic [7:0] instr);
        instr_t d;
        d.grp   = instr[7:6];
        d.subop = subop_e'(instr[5:2]);
        d.op2   = instr[5:4];
        d.arg0  = arg0(instr);
        d.arg1  = arg1(instr);
        d.imm   = instr[5:0];
        return d;
    endfunction

endpackage

// File: rtl/shader_core_pipe_mul.sv
// ---------------------------------------------------------------------------
// shader_mul_seq
//   Iterative shift-add multiplier returning the high half of op_a*op_b.
//   One multiplier bit per cycle; busy for exactly DATA_W cycles after start.
//   Only compiled into the core when SHADER_MUL_EN is defined.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   start          load operands and begin (ignored while busy)
//   abort          drop an in-flight multiply, no done pulse
//   op_a, op_b     multiplicand / multiplier
//   busy           multiply in progress
//   done           last iteration this cycle (combinational)
//   prod_hi        (op_a*op_b) >> DATA_W, valid while done is high
// ---------------------------------------------------------------------------
module shader_mul_seq #(
    parameter int DATA_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] prod_hi
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   sum;

    // Classic right-shifting accumulator: {hi,lo} holds partial product
    // with the untouched multiplier bits still sitting in lo.
    assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign done    = busy && (cnt == LAST);
    assign prod_hi = sum[DATA_W:1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy  <= 1'b0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            mcand <= op_a;
            hi    <= '0;
            lo    <= op_b;
            cnt   <= '0;
        end else if (busy) begin
            if (abort) begin
                busy <= 1'b0;
            end else begin
                hi  <= sum[DATA_W:1];
                lo  <= {sum[0], lo[DATA_W-1:1]};
                cnt <= cnt + 1'b1;
                if (cnt == LAST) busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shader_core_pipe.sv
// ---------------------------------------------------------------------------
// shader_core_pipe
//   Executes one 8-bit shader instruction per accepted valid/ready beat
//   against a 4-entry DATA_W register file, builds a working colour per
//   pixel and commits it to rgb_o on pixel_end_i.
//   Optional feature macro: SHADER_MUL_EN (adds the multi-cycle MUL opcode;
//   without it 00_1100_aa is a NOP and instr_ready_o is tied high).
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   instr_i/_valid_i    instruction beat in
//   instr_ready_o       core can accept (low only while MUL is running)
//   pixel_start_i       clear working colour/skip, abort MUL
//   pixel_end_i         commit working colour to rgb_o
//   x_pos_i, y_pos_i    pixel coordinates
//   time_i, user_i      frame time, user value
//   rgb_o               committed colour, R in the MSBs
//   rgb_valid_o         one-cycle pulse when rgb_o updates
// ---------------------------------------------------------------------------
module shader_core_pipe
    import shader_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int CH_W   = 2,
    localparam int RGB_W = 3 * CH_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        instr_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic              pixel_start_i,
    input  logic              pixel_end_i,
    input  logic [DATA_W-1:0] x_pos_i,
    input  logic [DATA_W-1:0] y_pos_i,
    input  logic [DATA_W-1:0] time_i,
    input  logic [DATA_W-1:0] user_i,
    output logic [RGB_W-1:0]  rgb_o,
    output logic              rgb_valid_o
);
    localparam logic [DATA_W-1:0] DW_L = DATA_W[DATA_W-1:0];

    logic [3:0][DATA_W-1:0] regs, regs_n;
    logic [RGB_W-1:0]       rgb, rgb_n;
    logic                   skip, skip_n;

    instr_t            d;
    logic              accept;
    logic              skip_eff;
    logic [DATA_W-1:0] ra, rb, r0;
    logic [3:0]        sine_idx;

    assign d        = decode(instr_i);
    assign accept   = instr_valid_i && instr_ready_o;
    // An instruction arriving with pixel_start_i sees the cleared skip.
    assign skip_eff = skip && !pixel_start_i;
    assign ra       = regs[d.arg0];
    assign rb       = regs[d.arg1];
    assign r0       = regs[0];
    assign sine_idx = r0[DATA_W-1 -: 4];

`ifdef SHADER_MUL_EN
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_prod;
    logic [1:0]        mul_dst;

    shader_mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (mul_start),
        .abort   (pixel_start_i),
        .op_a    (ra),
        .op_b    (r0),
        .busy    (mul_busy),
        .done    (mul_done),
        .prod_hi (mul_prod)
    );

    assign instr_ready_o = !mul_busy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          mul_dst <= '0;
        else if (mul_start) mul_dst <= d.arg0;
    end
`else
    assign instr_ready_o = 1'b1;
`endif

    always_comb begin
        regs_n = regs;
        rgb_n  = pixel_start_i ? '0 : rgb;
        skip_n = pixel_start_i ? 1'b0 : skip;
`ifdef SHADER_MUL_EN
        mul_start = 1'b0;
`endif
        if (accept) begin
            if (skip_eff) begin
                skip_n = 1'b0;
            end else begin
                case (d.grp)
                    GRP_SINGLE: begin
                        case (d.subop)
                            OP_SETRGB:  rgb_n = ra[RGB_W-1:0];
                            OP_SETR:    rgb_n[3*CH_W-1 -: CH_W] = ra[CH_W-1:0];
                            OP_SETG:    rgb_n[2*CH_W-1 -: CH_W] = ra[CH_W-1:0];
                            OP_SETB:    rgb_n[CH_W-1:0]         = ra[CH_W-1:0];
                            OP_GETX:    regs_n[d.arg0] = x_pos_i;
                            OP_GETY:    regs_n[d.arg0] = y_pos_i;
                            OP_GETTIME: regs_n[d.arg0] = time_i;
                            OP_GETUSER: regs_n[d.arg0] = user_i;
                            OP_IFEQ:    skip_n = !(ra == r0);
                            OP_IFNE:    skip_n = !(ra != r0);
                            OP_IFGE:    skip_n = !(ra >= r0);
                            OP_IFLT:    skip_n = !(ra <  r0);
`ifdef SHADER_MUL_EN
                            OP_MUL:     mul_start = 1'b1;
`endif
                            OP_DOUBLE:  regs_n[d.arg0] = ra << 1;
                            OP_HALF:    regs_n[d.arg0] = ra >> 1;
                            OP_SINE:    regs_n[d.arg0] =
                                            DATA_W'(SINE_LUT[sine_idx]) << (DATA_W - 6);
                            default: ;
                        endcase
                    end
                    GRP_LOGIC: begin
                        case (d.op2)
                            LOP_AND: regs_n[d.arg0] = ra & rb;
                            LOP_OR:  regs_n[d.arg0] = ra | rb;
                            LOP_NOT: regs_n[d.arg0] = ~rb;
                            default: regs_n[d.arg0] = ra ^ rb;
                        endcase
                    end
                    GRP_ARITH: begin
                        case (d.op2)
                            AOP_MOV: regs_n[d.arg0] = rb;
                            AOP_ADD: regs_n[d.arg0] = ra + rb;
                            // Oversized shift amounts flush to zero
                            AOP_SHL: regs_n[d.arg0] = (rb >= DW_L) ? '0 : (ra << rb);
                            default: regs_n[d.arg0] = (rb >= DW_L) ? '0 : (ra >> rb);
                        endcase
                    end
                    default: regs_n[0] = DATA_W'(d.imm);
                endcase
            end
        end
`ifdef SHADER_MUL_EN
        // No accept can coincide with done since ready is low while busy.
        if (mul_done && !pixel_start_i) regs_n[mul_dst] = mul_prod;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs        <= '0;
            rgb         <= '0;
            skip        <= 1'b0;
            rgb_o       <= '0;
            rgb_valid_o <= 1'b0;
        end else begin
            regs        <= regs_n;
            rgb         <= rgb_n;
            skip        <= skip_n;
            rgb_valid_o <= pixel_end_i;
            // Simultaneous start+end commits the colour from before the clear.
            if (pixel_end_i) rgb_o <= pixel_start_i ? rgb : rgb_n;
        end
    end

endmodule

// File: tb/tb_shader_core_pipe.sv
module tb_shader_core_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic       pstart = 1'b0;
    logic       pend = 1'b0;
    logic [5:0] xpos = '0, ypos = '0, tim = '0, usr = '0;
    logic [5:0] rgb;
    logic       rgb_vld;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shader_core_pipe #(.DATA_W(6), .CH_W(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_i       (instr),
        .instr_valid_i (valid),
        .instr_ready_o (ready),
        .pixel_start_i (pstart),
        .pixel_end_i   (pend),
        .x_pos_i       (xpos),
        .y_pos_i       (ypos),
        .time_i        (tim),
        .user_i        (usr),
        .rgb_o         (rgb),
        .rgb_valid_o   (rgb_vld)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, release #1 after the edge.
    task automatic cyc(input logic [7:0] ins, input logic v, input logic s, input logic e);
        @(negedge clk);
        instr = ins; valid = v; pstart = s; pend = e;
        @(posedge clk);
        #1;
        valid = 1'b0; pstart = 1'b0; pend = 1'b0;
    endtask

    // Read a register through SETRGB + commit (RGB_W == DATA_W here).
    task automatic peek_chk(input string tag, input logic [1:0] idx, input logic [5:0] exp);
        cyc({6'b0, idx}, 1'b1, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        chk(tag, rgb, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_rgb", rgb, 0);
        chk("rst_vld", rgb_vld, 0);
        chk("rst_rdy", ready, 1);
        @(negedge clk); rst = 1'b0;

        // Colour commit
        cyc(8'hEA, 1, 0, 0);   // LDI 42
        cyc(8'h81, 1, 0, 0);   // MOV r1,r0
        cyc(8'h01, 1, 0, 0);   // SETRGB r1
        chk("pre_end_vld", rgb_vld, 0);
        cyc(8'h00, 0, 0, 1);
        chk("commit_rgb", rgb, 6'b101010);
        chk("commit_vld", rgb_vld, 1);
        @(posedge clk); #1;
        chk("commit_vld_drop", rgb_vld, 0);

        // Skip
        cyc(8'hC5, 1, 1, 0);   // LDI 5 with pixel start (clears rgb)
        xpos = 6'd5;
        cyc(8'h11, 1, 0, 0);   // GETX r1
        cyc(8'h25, 1, 0, 0);   // IF r1!=r0 -> false -> skip
        cyc(8'h05, 1, 0, 0);   // SETR r1 (skipped)
        cyc(8'h00, 0, 0, 1);
        chk("skip_red", rgb, 6'b000000);
        cyc(8'h09, 1, 0, 0);   // SETG r1
        cyc(8'h00, 0, 0, 1);
        chk("skip_green", rgb, 6'b000100);

        // SINE
        cyc(8'hFF, 1, 0, 0); cyc(8'h3E, 1, 0, 0);
        peek_chk("sine63", 2'd2, 6'd63);
        cyc(8'hC0, 1, 0, 0); cyc(8'h3E, 1, 0, 0);
        peek_chk("sine0", 2'd2, 6'd0);
        cyc(8'hD4, 1, 0, 0); cyc(8'h3E, 1, 0, 0);
        peek_chk("sine20", 2'd2, 6'd31);

        // DOUBLE / HALF on r2=31
        cyc(8'h36, 1, 0, 0);
        peek_chk("double", 2'd2, 6'd62);
        cyc(8'h36, 1, 0, 0);
        peek_chk("double_wrap", 2'd2, 6'd60);
        cyc(8'h3A, 1, 0, 0);
        peek_chk("half", 2'd2, 6'd30);

        // ADD wrap, shifts, NOT, GETUSER
        cyc(8'hF2, 1, 0, 0); cyc(8'h81, 1, 0, 0); cyc(8'h91, 1, 0, 0);
        peek_chk("add_wrap", 2'd1, 6'd36);
        cyc(8'hC6, 1, 0, 0); cyc(8'hA1, 1, 0, 0);
        peek_chk("shl_big", 2'd1, 6'd0);
        cyc(8'hC5, 1, 0, 0); cyc(8'h81, 1, 0, 0); cyc(8'hC2, 1, 0, 0); cyc(8'hA1, 1, 0, 0);
        peek_chk("shl2", 2'd1, 6'd20);
        cyc(8'h63, 1, 0, 0);
        peek_chk("not", 2'd3, 6'd61);
        usr = 6'h2B;
        cyc(8'h1F, 1, 0, 0);
        peek_chk("getuser", 2'd3, 6'h2B);

        // pixel_start with same-cycle instruction, and start+end together
        cyc(8'hD4, 1, 0, 0); cyc(8'h81, 1, 0, 0); cyc(8'h01, 1, 0, 0);  // rgb=20
        cyc(8'hC7, 1, 0, 0); cyc(8'h81, 1, 0, 0); cyc(8'hC9, 1, 0, 0);  // r1=7, r0=9
        cyc(8'h21, 1, 0, 0);   // IF r1==r0 -> false -> skip
        cyc(8'h01, 1, 1, 0);   // SETRGB r1 alongside start: not skipped
        cyc(8'h00, 0, 1, 1);
        chk("start_end_pre", rgb, 6'd7);
        cyc(8'h00, 0, 0, 1);
        chk("start_cleared", rgb, 6'd0);

        // MUL setup: r1=48, r0=32
        cyc(8'hF0, 1, 0, 0); cyc(8'h81, 1, 0, 0); cyc(8'hE0, 1, 0, 0);
`ifdef SHADER_MUL_EN
        begin
            int n;
            n = 0;
            @(negedge clk); instr = 8'h31; valid = 1'b1;
            @(posedge clk); #1; instr = 8'h35;   // DOUBLE r1 held during busy
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (ready) break;
                n++;
            end
            @(posedge clk); #1; valid = 1'b0;
            chk("mul_busy_cycles", n, 6);
        end
        peek_chk("mul_then_double", 2'd1, 6'd48);
        // Abort in-flight MUL
        cyc(8'h31, 1, 0, 0);
        cyc(8'h00, 0, 0, 0);
        cyc(8'h00, 0, 1, 0);
        chk("abort_rdy", ready, 1);
        repeat (8) cyc(8'h00, 0, 0, 0);
        peek_chk("abort_nowrite", 2'd1, 6'd48);
        cyc(8'h31, 1, 0, 0);
        cyc(8'h00, 0, 0, 0);
`else
        cyc(8'h31, 1, 0, 0);
        chk("mul_nop_rdy", ready, 1);
        peek_chk("mul_nop", 2'd1, 6'd48);
`endif

        // Asynchronous reset between edges
        @(negedge clk); #2; rst = 1'b1;
        #1;
        chk("arst_rgb", rgb, 0);
        chk("arst_vld", rgb_vld, 0);
        chk("arst_rdy", ready, 1);
        @(negedge clk); rst = 1'b0;
        peek_chk("arst_r0", 2'd0, 6'd0);
        peek_chk("arst_r1", 2'd1, 6'd0);
        peek_chk("arst_r2", 2'd2, 6'd0);
        peek_chk("arst_r3", 2'd3, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
